// File: rtl/p4_pipe_addsub.sv
// Pipelined add/subtract datapath with valid/ready flow control.
// Stage 0 computes the full result; later elastic stages only carry it.
module p4_pipe_addsub #(
  parameter int DWIDTH    = 32,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DWIDTH-1:0]    A,
  input  logic [DWIDTH-1:0]    B,
  input  logic                 CIN,
  input  logic                 SUB,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DWIDTH-1:0]    S,
  output logic                 COUT,
  output logic                 OVF,
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam int RW = DWIDTH + 2;

  logic [DWIDTH-1:0]    b_eff;
  logic                 cin_eff;
  logic [DWIDTH:0]      sum;
  logic                 ovf_c;
  logic [STAGES-1:0]    vld;
  logic [STAGES-1:0]    adv;
  logic                 adv_chain;
  logic [RW-1:0]        data [STAGES];
  logic [CNT_WIDTH-1:0] cnt_q;

  always_comb begin
    b_eff   = SUB ? ~B : B;
    cin_eff = SUB ? ~CIN : CIN;
    sum     = {1'b0, A} + {1'b0, b_eff} + {{DWIDTH{1'b0}}, cin_eff};
    ovf_c   = (A[DWIDTH-1] == b_eff[DWIDTH-1]) && (sum[DWIDTH-1] != A[DWIDTH-1]);
  end

  // A stage may load when it is empty or its contents move on this cycle,
  // so bubbles are squeezed out while the output is stalled.
  always_comb begin
    adv              = '0;
    adv_chain        = !vld[STAGES-1] || out_ready;
    adv[STAGES-1]    = adv_chain;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_chain = !vld[k] || adv_chain;
      adv[k]    = adv_chain;
    end
  end

  assign in_ready = adv[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < STAGES; k++) data[k] <= '0;
    end else begin
      if (adv[0]) begin
        vld[0] <= in_valid;
        if (in_valid) data[0] <= {ovf_c, sum};
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) data[k] <= data[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (in_valid && in_ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign out_valid         = vld[STAGES-1];
  assign {OVF, COUT, S}    = data[STAGES-1];
  assign op_count          = cnt_q;

endmodule

// File: tb/tb_p4_pipe_addsub.sv
// Scoreboard bench for p4_pipe_addsub: a 32-bit/2-stage main instance plus
// 8-bit instances with STAGES=1..4 and a 4-bit saturating counter.
module tb_p4_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        cin, sub, cout, ovf;
  logic [15:0] op_count;

  logic       rin_valid;
  logic [7:0] ra, rb;
  logic       rcin, rsub;
  logic [3:0] rin_ready, rout_ready, rout_valid, rcout, rovf;
  logic [7:0] rs   [4];
  logic [3:0] rcnt [4];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int exp_cnt = 0;
  logic [33:0] q_exp[$];
  int          q_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  p4_pipe_addsub #(.DWIDTH(32), .STAGES(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .CIN(cin), .SUB(sub), .out_valid(out_valid),
    .out_ready(out_ready), .S(s), .COUT(cout), .OVF(ovf), .op_count(op_count));

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_reg
      p4_pipe_addsub #(.DWIDTH(8), .STAGES(g + 1), .CNT_WIDTH(4)) u (
        .clk(clk), .rst(rst), .in_valid(rin_valid), .in_ready(rin_ready[g]),
        .A(ra), .B(rb), .CIN(rcin), .SUB(rsub), .out_valid(rout_valid[g]),
        .out_ready(rout_ready[g]), .S(rs[g]), .COUT(rcout[g]), .OVF(rovf[g]),
        .op_count(rcnt[g]));
    end
  endgenerate

  // Reference: exact integer arithmetic, range test for signed overflow.
  function automatic logic [33:0] model(input int w, input logic [31:0] xa,
                                        input logic [31:0] xb, input logic xc,
                                        input logic xs);
    longint mask, ua, ub, sa, sb, r, sr, hi, lo, ci;
    logic c, o;
    mask = (longint'(1) << w) - 1;
    ua = longint'(xa) & mask;
    ub = longint'(xb) & mask;
    ci = xc ? 1 : 0;
    sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    if (!xs) begin
      r  = ua + ub + ci;
      c  = ((r >> w) & 1) != 0;
      sr = sa + sb + ci;
    end else begin
      r  = ua - ub - ci;
      c  = ua >= (ub + ci);
      sr = sa - sb - ci;
    end
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    o  = (sr > hi) || (sr < lo);
    return {o, c, 32'(r & mask)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    rin_valid = 1'b0; rout_ready = 4'hF; ra = '0; rb = '0; rcin = 1'b0; rsub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, ovf, cout, s} !== 35'd0) $display("FAIL reset_outputs: got %h expected 0", {out_valid, ovf, cout, s});
    else n_pass++;
    n_checks++;
    if (op_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", op_count);
    else n_pass++;
    n_checks++;
    if (rout_valid !== 4'b0) $display("FAIL reset_reg_valid: got %b expected 0000", rout_valid);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_vectors();
    logic [31:0] va [5] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'h80000000, 32'd1};
    logic [31:0] vb [5] = '{32'd1, 32'd1, 32'd7, 32'd0, 32'd1};
    logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [33:0] ve [5] = '{{2'b01, 32'h0}, {2'b10, 32'h80000000}, {2'b00, 32'hFFFFFFFE},
                            {2'b11, 32'h7FFFFFFF}, {2'b00, 32'd3}};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL vec_in_ready[%0d]: got %b expected 1", i, in_ready);
      else n_pass++;
      exp_cnt++;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL vec_early[%0d]: got out_valid %b expected 0", i, out_valid);
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, ovf, cout, s} !== {1'b1, ve[i]})
        $display("FAIL vec_result[%0d]: got %h expected %h", i, {out_valid, ovf, cout, s}, {1'b1, ve[i]});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, first = -1, last = -1, ac;
    logic [33:0] e;
    for (int i = 0; i < 40 && got < 10; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = (sent < 10);
      a = $urandom(); b = $urandom(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (q_exp.size() == 0) $display("FAIL b2b_extra: got unexpected result %h expected none", s);
        else begin
          e = q_exp.pop_front(); ac = q_cyc.pop_front();
          if ({ovf, cout, s} !== e || (cyc - ac) != 2)
            $display("FAIL b2b_result: got %h latency %0d expected %h latency 2", {ovf, cout, s}, cyc - ac, e);
          else n_pass++;
        end
        if (first < 0) first = cyc;
        last = cyc; got++;
      end
      if (in_valid && in_ready) begin
        q_exp.push_back(model(32, a, b, cin, sub)); q_cyc.push_back(cyc);
        sent++; exp_cnt++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != 10 || (last - first) != 9)
      $display("FAIL b2b_stream: got %0d results over %0d cycles expected 10 over 9", got, last - first);
    else n_pass++;
    n_checks++;
    if (op_count !== 16'(exp_cnt)) $display("FAIL b2b_count: got %0d expected %0d", op_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0;
    logic stalled_prev = 1'b0;
    logic [33:0] held = '0, e;
    for (int i = 0; i < 80 && got < 20; i++) begin
      @(posedge clk); #1;
      out_ready = !(i >= 6 && i <= 10);
      in_valid = (sent < 20) && (i != 4);
      a = $urandom(); b = $urandom(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled_prev) begin
        n_checks++;
        if ({ovf, cout, s} !== held) $display("FAIL bp_hold: got %h expected %h", {ovf, cout, s}, held);
        else n_pass++;
      end
      stalled_prev = out_valid && !out_ready;
      held = {ovf, cout, s};
      n_checks++;
      if (q_exp.size() > 2) $display("FAIL bp_depth: got %0d buffered expected at most 2", q_exp.size());
      else n_pass++;
      if (i == 10) begin
        n_checks++;
        if (in_ready !== 1'b0 || q_exp.size() != 2)
          $display("FAIL bp_full: got in_ready %b depth %0d expected 0 and 2", in_ready, q_exp.size());
        else n_pass++;
      end
      if (out_ready && q_exp.size() == 2) begin
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_pass_through: got in_ready %b expected 1", in_ready);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q_exp.size() == 0) $display("FAIL bp_extra: got unexpected result %h expected none", s);
        else begin
          e = q_exp.pop_front(); void'(q_cyc.pop_front());
          if ({ovf, cout, s} !== e) $display("FAIL bp_result: got %h expected %h", {ovf, cout, s}, e);
          else n_pass++;
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q_exp.push_back(model(32, a, b, cin, sub)); q_cyc.push_back(cyc);
        sent++; exp_cnt++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got != 20) $display("FAIL bp_complete: got %0d results expected 20", got);
    else n_pass++;
    n_checks++;
    if (op_count !== 16'(exp_cnt)) $display("FAIL bp_count: got %0d expected %0d", op_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd10; b = 32'd20; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a = 32'd30; b = 32'd40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || op_count !== 16'(exp_cnt + 2))
      $display("FAIL rst_pre: got valid %b ready %b count %0d expected 1 0 %0d",
               out_valid, in_ready, op_count, exp_cnt + 2);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, s, op_count} !== 49'd0)
      $display("FAIL rst_async: got valid %b S %h count %0d expected all 0", out_valid, s, op_count);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    exp_cnt = 0; q_exp.delete(); q_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || op_count !== 16'd0)
        $display("FAIL rst_stale[%0d]: got valid %b count %0d expected 0 0", i, out_valid, op_count);
      else n_pass++;
    end
  endtask

  task automatic test_regression();
    logic [9:0] rbuf [4][32];
    int rhd [4] = '{0, 0, 0, 0};
    int rtl_ [4] = '{0, 0, 0, 0};
    int acc [4] = '{0, 0, 0, 0};
    logic [33:0] m;
    logic [9:0] e;
    for (int i = 0; i < 320; i++) begin
      @(posedge clk); #1;
      if (i < 300) begin
        rin_valid = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) rout_ready[k] = ($urandom_range(0, 9) < 7);
      end else begin
        rin_valid = 1'b0; rout_ready = 4'hF;
      end
      ra = 8'($urandom()); rb = 8'($urandom());
      rcin = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (rcnt[k] !== 4'((acc[k] > 15) ? 15 : acc[k]))
          $display("FAIL reg_count[S%0d]: got %0d expected %0d", k + 1, rcnt[k], (acc[k] > 15) ? 15 : acc[k]);
        else n_pass++;
        if (rout_valid[k] && rout_ready[k]) begin
          n_checks++;
          if (rtl_[k] == rhd[k]) $display("FAIL reg_extra[S%0d]: got result %h expected none", k + 1, rs[k]);
          else begin
            e = rbuf[k][rhd[k] % 32]; rhd[k]++;
            if ({rovf[k], rcout[k], rs[k]} !== e)
              $display("FAIL reg_result[S%0d]: got %h expected %h", k + 1, {rovf[k], rcout[k], rs[k]}, e);
            else n_pass++;
          end
        end
        if (rin_valid && rin_ready[k]) begin
          m = model(8, {24'b0, ra}, {24'b0, rb}, rcin, rsub);
          rbuf[k][rtl_[k] % 32] = {m[33:32], m[7:0]};
          rtl_[k]++; acc[k]++;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rtl_[k] != rhd[k]) $display("FAIL reg_drain[S%0d]: got %0d outstanding expected 0", k + 1, rtl_[k] - rhd[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_regression();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
